// File: rtl/system_exec_ctrl.sv
// Execute-stage sequencer for RV32I SYSTEM instructions: Zicsr read-modify-write
// over a req/ack CSR port, plus trap requests for ecall/ebreak/illegal encodings.
package system_exec_pkg;
  typedef enum logic [3:0] {
    sysk_invalid, sysk_ecall, sysk_ebreak,
    sysk_csrrw, sysk_csrrs, sysk_csrrc,
    sysk_csrrwi, sysk_csrrsi, sysk_csrrci
  } system_kind_t;
endpackage

module system_exec_ctrl
  import system_exec_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  system_kind_t     in_kind,
  input  logic [11:0]      in_csr_addr,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [XLEN-1:0]  in_rs1_val,
  input  logic [XLEN-1:0]  in_pc,
  output logic             csr_req,
  output logic             csr_we,
  output logic [11:0]      csr_addr,
  output logic [XLEN-1:0]  csr_wdata,
  input  logic [XLEN-1:0]  csr_rdata,
  input  logic             csr_ack,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             done,
  output logic             trap_valid,
  output logic [3:0]       trap_cause,
  output logic [XLEN-1:0]  trap_epc
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD, WR, RESP, TRAP} state_t;

  state_t            state, state_nxt;
  system_kind_t      kind_q;
  logic [11:0]       addr_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   src_q, pc_q, old_q;
  logic              do_rd_q, do_wr_q;
  logic [3:0]        cause_q;
  logic [CW-1:0]     cnt_q;

  logic              acc_is_w, acc_is_imm, acc_is_csr, acc_do_rd, acc_do_wr;
  logic [3:0]        acc_cause;
  logic [XLEN-1:0]   acc_src;
  logic              accept, timeout;

  assign accept     = in_valid && (state == IDLE);
  assign timeout    = (cnt_q == CW'(ACK_TIMEOUT - 1));
  assign acc_is_w   = in_kind inside {sysk_csrrw, sysk_csrrwi};
  assign acc_is_imm = in_kind inside {sysk_csrrwi, sysk_csrrsi, sysk_csrrci};
  assign acc_is_csr = in_kind inside {sysk_csrrw, sysk_csrrs, sysk_csrrc,
                                      sysk_csrrwi, sysk_csrrsi, sysk_csrrci};
  assign acc_do_rd  = !(acc_is_w && in_rd == 5'd0);
  assign acc_do_wr  = acc_is_w || (in_rs1 != 5'd0);
  assign acc_src    = acc_is_imm ? {{(XLEN-5){1'b0}}, in_rs1} : in_rs1_val;

  // Nonzero cause means the instruction traps without touching the CSR file.
  always_comb begin
    acc_cause = 4'd0;
    case (in_kind)
      sysk_ecall:  acc_cause = 4'd11;
      sysk_ebreak: acc_cause = 4'd3;
      default: begin
        if (!acc_is_csr)
          acc_cause = 4'd2;
        else if (acc_do_wr && in_csr_addr[11:10] == 2'b11)
          acc_cause = 4'd2;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) begin
        if (acc_cause != 4'd0) state_nxt = TRAP;
        else if (acc_do_rd)    state_nxt = RD;
        else                   state_nxt = WR;
      end
      RD: begin
        if (csr_ack)      state_nxt = do_wr_q ? WR : RESP;
        else if (timeout) state_nxt = TRAP;
      end
      WR: begin
        if (csr_ack)      state_nxt = RESP;
        else if (timeout) state_nxt = TRAP;
      end
      RESP:    state_nxt = IDLE;
      TRAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      kind_q  <= sysk_invalid;
      addr_q  <= '0;
      rd_q    <= '0;
      src_q   <= '0;
      pc_q    <= '0;
      old_q   <= '0;
      do_rd_q <= 1'b0;
      do_wr_q <= 1'b0;
      cause_q <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)                cnt_q <= '0;
      else if (state == RD || state == WR)   cnt_q <= cnt_q + 1'b1;
      if (accept) begin
        kind_q  <= in_kind;
        addr_q  <= in_csr_addr;
        rd_q    <= in_rd;
        src_q   <= acc_src;
        pc_q    <= in_pc;
        old_q   <= '0;
        do_rd_q <= acc_do_rd;
        do_wr_q <= acc_do_wr;
        cause_q <= acc_cause;
      end else if ((state == RD || state == WR) && state_nxt == TRAP) begin
        cause_q <= 4'd2;
      end
      if (state == RD && csr_ack) old_q <= csr_rdata;
    end
  end

  // All request fields come from latched state, so they hold while csr_req is up.
  always_comb begin
    csr_wdata = '0;
    if (state == WR) begin
      case (kind_q)
        sysk_csrrw, sysk_csrrwi: csr_wdata = src_q;
        sysk_csrrs, sysk_csrrsi: csr_wdata = old_q | src_q;
        sysk_csrrc, sysk_csrrci: csr_wdata = old_q & ~src_q;
        default:                 csr_wdata = '0;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign csr_req    = (state == RD) || (state == WR);
  assign csr_we     = (state == WR);
  assign csr_addr   = addr_q;
  assign done       = (state == RESP);
  assign wb_valid   = (state == RESP) && do_rd_q && (rd_q != 5'd0);
  assign wb_rd      = rd_q;
  assign wb_data    = old_q;
  assign trap_valid = (state == TRAP);
  assign trap_cause = cause_q;
  assign trap_epc   = pc_q;

endmodule

// File: tb/tb_system_exec_ctrl.sv
// Randomized bench for system_exec_ctrl: a CSR responder with programmable ack
// delays and a transaction-level model predicting accesses, outcome and latency.
module tb_system_exec_ctrl;
  import system_exec_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  system_kind_t in_kind;
  logic [11:0]  in_csr_addr;
  logic [4:0]   in_rd, in_rs1;
  logic [31:0]  in_rs1_val, in_pc;
  logic         csr_req, csr_we, csr_ack;
  logic [11:0]  csr_addr;
  logic [31:0]  csr_wdata, csr_rdata;
  logic         wb_valid, done, trap_valid;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data, trap_epc;
  logic [3:0]   trap_cause;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  system_exec_ctrl #(.XLEN(32), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_csr_addr(in_csr_addr), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs1_val(in_rs1_val), .in_pc(in_pc),
    .csr_req(csr_req), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_ack(csr_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .done(done),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_epc(trap_epc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one instruction; the responder acks reads after dr idle cycles and
  // writes after dw idle cycles (15 or more means never, i.e. timeout).
  task automatic run(input system_kind_t k, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [31:0] v, input logic [11:0] a, input logic [31:0] pc,
                     input int dr, input int dw, input logic [31:0] rdata, input bit spur);
    bit is_csr, is_w, is_s, is_imm, e_rd, e_wr, got_trap, fin, prev_req, prev_we, stable;
    logic [31:0] src, old, e_wd, wd_seen, g_epc, g_wbd;
    logic [11:0] a_seen;
    logic [3:0] g_cause;
    logic [4:0] g_wbrd;
    logic g_wbv;
    int pre, t, e_nrd, e_nwr, nrd, nwr, g_cyc, wait_c, e_cause;

    is_csr = k inside {sysk_csrrw, sysk_csrrs, sysk_csrrc, sysk_csrrwi, sysk_csrrsi, sysk_csrrci};
    is_w   = k inside {sysk_csrrw, sysk_csrrwi};
    is_s   = k inside {sysk_csrrs, sysk_csrrsi};
    is_imm = k inside {sysk_csrrwi, sysk_csrrsi, sysk_csrrci};
    src    = is_imm ? {27'd0, rs1} : v;
    e_rd   = !(is_w && rd == 0);
    e_wr   = is_w || rs1 != 0;
    if (k == sysk_ecall)                          pre = 11;
    else if (k == sysk_ebreak)                    pre = 3;
    else if (!is_csr)                             pre = 2;
    else if (e_wr && a[11:10] == 2'b11)           pre = 2;
    else                                          pre = 0;

    t = 1; e_cause = pre; e_nrd = 0; e_nwr = 0;
    if (pre == 0 && e_rd) begin
      e_nrd = 1;
      if (dr >= 15) begin e_cause = 2; t += 15; end
      else t += dr + 1;
    end
    if (e_cause == 0 && e_wr) begin
      e_nwr = 1;
      if (dw >= 15) begin e_cause = 2; t += 15; end
      else t += dw + 1;
    end

    @(negedge clk);
    chk("ready_idle", in_ready, 1);
    in_valid = 1'b1; in_kind = k; in_rd = rd; in_rs1 = rs1;
    in_rs1_val = v; in_csr_addr = a; in_pc = pc;
    csr_ack = spur;  // lands while idle; must be ignored

    got_trap = 0; fin = 0; prev_req = 0; prev_we = 0; stable = 1;
    nrd = 0; nwr = 0; g_cyc = 0; wait_c = 0; wd_seen = 0; a_seen = 0;
    g_cause = 0; g_epc = 0; g_wbv = 0; g_wbrd = 0; g_wbd = 0;
    for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      csr_ack  = 1'b0;
      if (trap_valid) begin
        fin = 1; got_trap = 1; g_cyc = cyc; g_cause = trap_cause; g_epc = trap_epc;
      end else if (done) begin
        fin = 1; g_cyc = cyc; g_wbv = wb_valid; g_wbrd = wb_rd; g_wbd = wb_data;
      end else if (csr_req) begin
        if (!prev_req || prev_we != csr_we) begin
          wait_c = 0; a_seen = csr_addr;
          if (csr_we) begin nwr++; wd_seen = csr_wdata; end
          else nrd++;
        end else if (csr_addr !== a_seen || (csr_we && csr_wdata !== wd_seen)) begin
          stable = 0;
        end
        if (wait_c == (csr_we ? dw : dr)) begin
          csr_ack = 1'b1;
          if (!csr_we) csr_rdata = rdata;
        end
        wait_c++;
      end
      prev_req = csr_req; prev_we = csr_we;
    end

    old  = (e_nrd != 0) ? rdata : 32'd0;
    e_wd = is_w ? src : (is_s ? (old | src) : (old & ~src));

    chk("outcome_trap", got_trap, e_cause != 0);
    chk("latency", g_cyc, t);
    chk("num_reads", nrd, e_nrd);
    chk("num_writes", nwr, e_nwr);
    chk("req_stable", stable, 1);
    if (nrd + nwr > 0) chk("csr_addr", a_seen, a);
    if (e_nwr != 0 && nwr != 0) chk("wdata", wd_seen, e_wd);
    if (e_cause != 0) begin
      chk("trap_cause", g_cause, e_cause);
      chk("trap_epc", g_epc, pc);
    end else begin
      chk("wb_valid", g_wbv, e_rd && rd != 0);
      if (e_rd && rd != 0) begin
        chk("wb_rd", g_wbrd, rd);
        chk("wb_data", g_wbd, old);
      end
    end
  endtask

  initial begin
    logic [4:0] r_rd, r_rs1;
    logic [11:0] r_a;
    int r, dr, dw;

    rst = 1'b1; in_valid = 0; in_kind = sysk_invalid; in_csr_addr = 0; in_rd = 0;
    in_rs1 = 0; in_rs1_val = 0; in_pc = 0; csr_ack = 0; csr_rdata = 0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_req", csr_req, 0);
    chk("rst_done", done, 0);
    chk("rst_trap", trap_valid, 0);
    chk("rst_wb", wb_valid, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_epc", trap_epc, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run(sysk_csrrs,  5'd5, 5'd1, 32'h0F,   12'h300, 32'h10, 0, 0, 32'hF0, 0);
    run(sysk_csrrw,  5'd0, 5'd2, 32'h1234, 12'h340, 32'h14, 0, 0, 32'h0,  0);
    run(sysk_csrrci, 5'd3, 5'd0, 32'h0,    12'hC00, 32'h18, 1, 0, 32'hABCD_0001, 1);
    run(sysk_csrrw,  5'd4, 5'd7, 32'h55,   12'hC00, 32'h1C, 0, 0, 32'h0,  0);
    run(sysk_ecall,  5'd0, 5'd0, 32'h0,    12'h000, 32'h80, 0, 0, 32'h0,  0);
    run(sysk_ebreak, 5'd0, 5'd0, 32'h0,    12'h001, 32'h84, 0, 0, 32'h0,  0);
    run(sysk_invalid,5'd1, 5'd1, 32'h0,    12'h300, 32'h88, 0, 0, 32'h0,  0);
    run(sysk_csrrs,  5'd6, 5'd1, 32'h3,    12'h305, 32'h8C, 15, 0, 32'h7,  0);
    run(sysk_csrrs,  5'd6, 5'd1, 32'h3,    12'h305, 32'h90, 14, 14, 32'h7, 0);
    run(sysk_csrrc,  5'd7, 5'd9, 32'hFF,   12'h341, 32'h94, 2, 15, 32'h1FF, 0);
    run(sysk_csrrwi, 5'd8, 5'd31,32'h0,    12'h342, 32'h98, 0, 3, 32'hDEAD_BEEF, 0);

    for (int i = 0; i < 250; i++) begin
      r_rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      r_rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      r_a   = 12'($urandom);
      if ($urandom_range(0, 3) == 0) r_a[11:10] = 2'b11;
      r  = $urandom_range(0, 19);
      dr = (r < 16) ? r % 4 : (r < 18 ? 14 : 15);
      r  = $urandom_range(0, 19);
      dw = (r < 16) ? r % 4 : (r < 18 ? 14 : 15);
      run(system_kind_t'($urandom_range(0, 8)), r_rd, r_rs1, $urandom, r_a, $urandom,
          dr, dw, $urandom, $urandom_range(0, 4) == 0);
    end

    // Reset in the middle of a write access
    @(negedge clk);
    in_valid = 1; in_kind = sysk_csrrw; in_rd = 0; in_rs1 = 3;
    in_rs1_val = 32'h77; in_csr_addr = 12'h300; in_pc = 32'h200;
    @(negedge clk);
    in_valid = 0;
    chk("pre_rst_req", csr_req, 1);
    chk("pre_rst_we", csr_we, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", csr_req, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    run(sysk_csrrs, 5'd2, 5'd1, 32'h1, 12'h300, 32'h204, 0, 0, 32'h10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
